// File: rtl/bus_access_ctrl.sv
// bus_access_ctrl
//   Sequences MEM-stage accesses routed to the external peripheral bus
//   (m_sel=1). It runs a valid/ready handshake, holds the pipeline through
//   stall_M until the transfer ends, and returns load data to writeback.
//   Accesses with m_sel=0 go to DMEM and are ignored here.
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   - REQ aborts after TIMEOUT_CYC cycles without ready and
//                 pulses bus_err in DONE (load data forced to zero).
//     undefined - REQ waits indefinitely and bus_err is tied low.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   m_sel, addr_bus            address-decode select and bus address
//   mem_read_M, mem_write_M    MEM-stage load / store (write wins if both)
//   wdata_M, wstrb_M           store data and byte enables
//   stall_M                    holds IF..MEM while a bus access is pending
//   rdata_bus_M                load data, valid in the DONE cycle
//   bus_valid, bus_addr, bus_we, bus_wdata, bus_wstrb
//                              latched request towards the peripheral
//   bus_ready, bus_rdata       peripheral accept/complete and read data
//   bus_err                    one-cycle pulse in DONE on an aborted transfer
module bus_access_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_sel,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              mem_read_M,
  input  logic              mem_write_M,
  input  logic [DATA_W-1:0] wdata_M,
  input  logic [3:0]        wstrb_M,
  output logic              stall_M,
  output logic [DATA_W-1:0] rdata_bus_M,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state;
  logic   start;
  logic   timeout;

  assign start = m_sel & (mem_read_M | mem_write_M);

  // The stall must rise in the same cycle the access appears, before the
  // FSM has left IDLE; in DONE it drops so the instruction retires.
  assign stall_M = (state == REQ) | ((state == IDLE) & start);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // A ready in the limit cycle takes priority over the abort.
  assign timeout = (state == REQ) & ~bus_ready &
                   (wait_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      // timeout is only true in the last REQ cycle, so this lands in DONE
      bus_err <= timeout;
      if ((state == IDLE) && start) begin
        wait_cnt <= '0;
      end else if ((state == REQ) && !bus_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus_valid   <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      rdata_bus_M <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_addr  <= addr_bus;
            bus_wdata <= wdata_M;
            bus_we    <= mem_write_M;
            bus_wstrb <= mem_write_M ? wstrb_M : '0;
            bus_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // bus_valid is always high here, so ready alone marks the handshake
          if (bus_ready) begin
            if (!bus_we) begin
              rdata_bus_M <= bus_rdata;
            end
            bus_valid <= 1'b0;
            state     <= DONE;
          end else if (timeout) begin
            if (!bus_we) begin
              rdata_bus_M <= '0;
            end
            bus_valid <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_access_ctrl.sv
module tb_bus_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_sel;
  logic [31:0] addr_bus;
  logic        mem_read_M;
  logic        mem_write_M;
  logic [31:0] wdata_M;
  logic [3:0]  wstrb_M;
  logic        stall_M;
  logic [31:0] rdata_bus_M;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  bus_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_sel(m_sel),
    .addr_bus(addr_bus),
    .mem_read_M(mem_read_M),
    .mem_write_M(mem_write_M),
    .wdata_M(wdata_M),
    .wstrb_M(wstrb_M),
    .stall_M(stall_M),
    .rdata_bus_M(rdata_bus_M),
    .bus_valid(bus_valid),
    .bus_addr(bus_addr),
    .bus_we(bus_we),
    .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready),
    .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus access: cycle 0 in IDLE, REQ cycles, then DONE. Inputs stay on
  // through DONE (instruction still in MEM); the caller follows with another
  // access or with idle cycles.
  task automatic bus_op(input string name, input bit wr, input bit both,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] rd,
                        input int n_ready);
    int   exp_req;
    bit   exp_err;
    int   stalls;
    exp_t e;
    stalls = 0;
`ifdef BUS_TIMEOUT_EN
    if (n_ready >= 1 && n_ready <= int'(TO) + 1) begin
      exp_req = n_ready;
      exp_err = 1'b0;
    end else begin
      exp_req = int'(TO) + 1;
      exp_err = 1'b1;
    end
`else
    exp_req = n_ready;
    exp_err = 1'b0;
`endif
    if (!wr) model_rdata = exp_err ? 32'h0 : rd;
    e.rdata = model_rdata;
    e.err   = exp_err;
    sb.push_back(e);

    @(posedge clk); #1;
    m_sel       = 1'b1;
    mem_read_M  = !wr || both;
    mem_write_M = wr;
    addr_bus    = a;
    wdata_M     = wd;
    wstrb_M     = ws;
    bus_ready   = 1'b0;
    @(negedge clk);
    if (stall_M) stalls++;
    chk({name, " idle_valid"}, 32'(bus_valid), 32'h0);

    for (int k = 1; k <= exp_req; k++) begin
      @(posedge clk); #1;
      bus_ready = (k == n_ready);
      bus_rdata = (k == n_ready) ? rd : ~rd;
      // live inputs wander during REQ; the latched copies must not
      addr_bus  = ~a;
      wdata_M   = ~wd;
      wstrb_M   = ~ws;
      @(negedge clk);
      if (stall_M) stalls++;
      chk({name, " req_valid"}, 32'(bus_valid), 32'h1);
      chk({name, " req_addr"}, bus_addr, a);
      chk({name, " req_we"}, 32'(bus_we), 32'(wr));
      chk({name, " req_wstrb"}, 32'(bus_wstrb), wr ? 32'(ws) : 32'h0);
      if (wr) chk({name, " req_wdata"}, bus_wdata, wd);
      chk({name, " req_err"}, 32'(bus_err), 32'h0);
    end

    @(posedge clk); #1;
    addr_bus  = a;
    bus_ready = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (stall_M) stalls++;
    chk({name, " done_valid"}, 32'(bus_valid), 32'h0);
    if (sb.size() == 0) begin
      chk({name, " sb_underflow"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      chk({name, " done_rdata"}, rdata_bus_M, e.rdata);
      chk({name, " done_err"}, 32'(bus_err), 32'(e.err));
    end
    chk({name, " stall_cycles"}, 32'(stalls), 32'(exp_req + 1));
  endtask

  // Non-bus cycles: DMEM load (m_sel=0) with a stray ready on the bus.
  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_sel       = 1'b0;
      mem_read_M  = 1'b1;
      mem_write_M = 1'b0;
      addr_bus    = 32'h0000_01FC;
      bus_ready   = 1'b1;
      bus_rdata   = 32'h7777_7777;
      @(negedge clk);
      chk({name, " valid"}, 32'(bus_valid), 32'h0);
      chk({name, " stall"}, 32'(stall_M), 32'h0);
      chk({name, " rdata_hold"}, rdata_bus_M, model_rdata);
      chk({name, " err"}, 32'(bus_err), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    m_sel       = 1'b0;
    addr_bus    = '0;
    mem_read_M  = 1'b0;
    mem_write_M = 1'b0;
    wdata_M     = '0;
    wstrb_M     = '0;
    bus_ready   = 1'b0;
    bus_rdata   = '0;
    model_rdata = '0;

    #3;
    chk("rst valid", 32'(bus_valid), 32'h0);
    chk("rst we", 32'(bus_we), 32'h0);
    chk("rst err", 32'(bus_err), 32'h0);
    chk("rst addr", bus_addr, 32'h0);
    chk("rst wdata", bus_wdata, 32'h0);
    chk("rst wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst rdata", rdata_bus_M, 32'h0);
    chk("rst stall", 32'(stall_M), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    bus_op("t1_load", 1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'hCAFE_F00D, 3);
    bus_op("t2_store", 1'b1, 1'b0, 32'h0000_0204, 32'h1234_5678, 4'b0011, 32'hFFFF_0000, 1);
    idle_cycles("t3_dmem", 4);
    bus_op("t4_load_a", 1'b0, 1'b0, 32'h0000_0208, 32'h0, 4'h0, 32'h1111_2222, 2);
    bus_op("t4_load_b", 1'b0, 1'b0, 32'h0000_020C, 32'h0, 4'h0, 32'h3333_4444, 1);
    bus_op("rw_both", 1'b1, 1'b1, 32'h0000_0210, 32'hA5A5_A5A5, 4'b1111, 32'h0, 2);
    bus_op("t5_noready", 1'b0, 1'b0, 32'h0000_0214, 32'h0, 4'h0, 32'h55AA_55AA, 12);
    bus_op("t5_limit", 1'b0, 1'b0, 32'h0000_0218, 32'h0, 4'h0, 32'h0BAD_F00D, int'(TO) + 1);
    idle_cycles("t5_after", 2);

    // reset in the middle of REQ
    @(posedge clk); #1;
    m_sel       = 1'b1;
    mem_read_M  = 1'b1;
    mem_write_M = 1'b0;
    addr_bus    = 32'h0000_0300;
    bus_ready   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6 pre_valid", 32'(bus_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async_valid", 32'(bus_valid), 32'h0);
    chk("t6 async_addr", bus_addr, 32'h0);
    chk("t6 async_err", 32'(bus_err), 32'h0);
    chk("t6 idle_stall_start", 32'(stall_M), 32'h1);
    m_sel      = 1'b0;
    mem_read_M = 1'b0;
    model_rdata = 32'h0;
    #1;
    chk("t6 idle_stall_nostart", 32'(stall_M), 32'h0);
    chk("t6 rst_rdata", rdata_bus_M, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_op("t6_after", 1'b0, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 32'h600D_CAFE, 2);
    idle_cycles("t6_idle", 1);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
